btn_debounce_press: RTL and testbench
=====================================

Name: btn_debounce_press

Overview:
Receive-side counterpart of the board's timed LED drivers. Conditions a raw push-button input into clean, single-cycle press and release events, plus a long-press indication and a hold-time measurement. Timing is derived from a millisecond tick generated from CLK_FREQ. It sits between the board button pins and control logic such as mode selection and LED blink enables.

Parameters:
CLK_FREQ, 125_000_000, input clock frequency in Hz; TPM = CLK_FREQ/1000 cycles per ms (integer divide).
DEBOUNCE_MS, 20, stable-level time in ms required to accept a press or release.
LONG_PRESS_MS, 1000, hold time in ms, measured from press acceptance, that triggers the long-press event.

Ports:
CLK  in  1  system clock
RST  in  1  reset, asynchronous, active-high
BTN_IN  in  1  raw button level (1 = pressed), asynchronous to CLK
BTN_LEVEL  out  1  debounced button level
PRESS_PULSE  out  1  one-cycle strobe when a press is accepted
RELEASE_PULSE  out  1  one-cycle strobe when a release is accepted
LONG_PULSE  out  1  one-cycle strobe when the hold time reaches LONG_PRESS_MS
LONG_FLAG  out  1  high from LONG_PULSE until the release is accepted
HOLD_MS  out  16  hold duration in ms of the last completed press, saturating

Behaviour:
- Reset (async, RST=1):
  - FSM to IDLE.
  - Both synchronizer flops, ms prescaler, ms counter and hold counter to 0.
  - All outputs to 0.
  - Asserting reset mid-operation aborts at once, with no pulses generated.
- Synchronizer: two flops on BTN_IN produce btn_s. All logic uses btn_s only.
- ms prescaler:
  - Counts 0..TPM-1 and wraps.
  - tick=1 for the single cycle when count==TPM-1.
  - Cleared to 0 on every FSM state change.
- IDLE:
  - btn_s=1 moves to PRESS_WAIT and clears the ms counter.
- PRESS_WAIT:
  - btn_s=0 returns to IDLE (bounce). No outputs change.
  - Otherwise the ms counter increments on tick.
  - On the tick that completes DEBOUNCE_MS ms (DEBOUNCE_MS*TPM cycles in state), move to PRESSED.
  - On that transition: PRESS_PULSE=1 for one cycle, BTN_LEVEL<=1, hold counter<=0.
- PRESSED:
  - btn_s=0 moves to RELEASE_WAIT. This takes priority over a coincident tick; the hold counter does not count that cycle.
  - Otherwise the hold counter increments on tick, saturating at 16'hFFFF.
  - When the hold counter reaches LONG_PRESS_MS: LONG_PULSE=1 for one cycle and LONG_FLAG<=1. This fires at most once per press.
- RELEASE_WAIT:
  - The hold counter is frozen.
  - btn_s=1 returns to PRESSED (bounce). No pulse, no BTN_LEVEL change; the hold counter resumes from its frozen value.
  - After DEBOUNCE_MS ms of stable btn_s=0, move to IDLE.
  - On that transition: RELEASE_PULSE=1 for one cycle, BTN_LEVEL<=0, LONG_FLAG<=0, HOLD_MS<=hold counter.
- Latency:
  - Take edge 1 as the first rising edge that samples BTN_IN=1 and edge 2 as the edge at which btn_s becomes 1.
  - The FSM enters PRESS_WAIT at edge 3.
  - PRESS_PULSE is visible after edge DEBOUNCE_MS*TPM+3.
  - Release latency is the same, measured from the first edge that samples BTN_IN=0.
- Pulse exclusivity:
  - PRESS_PULSE, RELEASE_PULSE and LONG_PULSE are registered and never coincide.
  - LONG_PULSE never occurs outside PRESSED.
- Accuracy: partial ms lost on a bounce back into PRESSED is accepted (prescaler cleared).

Decomposition:
- Shared package holds:
  - the FSM state encoding (IDLE=0, PRESS_WAIT=1, PRESSED=2, RELEASE_WAIT=3);
  - a TPM constant function (CLK_FREQ/1000);
  - the 16-bit saturating maximum.
- One sub-module: ms_tick_gen.
  - Parameter CLK_FREQ.
  - Ports CLK, RST, CLR, TICK.
  - Free-running prescaler with synchronous clear.

Test Plan:
All scenarios use CLK_FREQ=10_000 (TPM=10), DEBOUNCE_MS=2 (20 cycles), LONG_PRESS_MS=5.
1. Release RST, BTN_IN=0 for 50 cycles -> all outputs stay 0; FSM stays IDLE.
2. BTN_IN=1 held 40 cycles -> PRESS_PULSE high for exactly 1 cycle after edge 23; BTN_LEVEL=1 from then on; no other pulses.
3. BTN_IN=1 for 15 cycles, then 0, repeated 3 times -> no PRESS_PULSE; BTN_LEVEL stays 0.
4. Press accepted, held 80 cycles more, then released -> LONG_PULSE 50 cycles after PRESS_PULSE and LONG_FLAG=1; RELEASE_PULSE 23 edges after release; HOLD_MS=8; LONG_FLAG=0.
5. While pressed, BTN_IN=0 for 10 cycles, then 1 -> no RELEASE_PULSE, no second PRESS_PULSE; BTN_LEVEL stays 1.
6. Assert RST asynchronously (mid-cycle) while in PRESSED with LONG_FLAG=1 -> all outputs 0 immediately, before the next edge; after reset release with BTN_IN still 1, a new PRESS_PULSE occurs 23 edges later.

Source files
------------

// File: rtl/btn_debounce_press_pkg.sv
// Shared definitions for the push-button conditioner: FSM encoding,
// millisecond prescaler sizing and the saturation limit of the hold counter.
package btn_debounce_press_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } state_e;

  localparam logic [15:0] SAT_MAX = 16'hFFFF;

  function automatic int tpm(input int clk_freq);
    return clk_freq / 1000;
  endfunction

endpackage

// File: rtl/btn_debounce_press_ms_tick_gen.sv
// Free-running millisecond prescaler; TICK marks the last cycle of each ms.
// CLR restarts the count so a new FSM state always begins on a ms boundary.
module ms_tick_gen
  import btn_debounce_press_pkg::*;
#(
  parameter int CLK_FREQ = 125_000_000
) (
  input  logic CLK,
  input  logic RST,
  input  logic CLR,
  output logic TICK
);

  localparam int TPM = tpm(CLK_FREQ);
  localparam int CW  = (TPM > 1) ? $clog2(TPM) : 1;
  localparam logic [CW-1:0] LAST = CW'(TPM - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    if (CLR) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign TICK = (cnt_q == LAST);

endmodule

// File: rtl/btn_debounce_press.sv
// Push-button conditioner: synchronizes the raw pin, debounces press and release,
// and reports single-cycle events, a long-press flag and the last hold time in ms.
module btn_debounce_press
  import btn_debounce_press_pkg::*;
#(
  parameter int CLK_FREQ      = 125_000_000,
  parameter int DEBOUNCE_MS   = 20,
  parameter int LONG_PRESS_MS = 1000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        BTN_IN,
  output logic        BTN_LEVEL,
  output logic        PRESS_PULSE,
  output logic        RELEASE_PULSE,
  output logic        LONG_PULSE,
  output logic        LONG_FLAG,
  output logic [15:0] HOLD_MS
);

  localparam logic [15:0] DEB_LAST  = 16'(DEBOUNCE_MS - 1);
  localparam logic [15:0] LONG_LAST = 16'(LONG_PRESS_MS - 1);
  // A long-press target the 16-bit hold counter cannot reach never fires.
  localparam logic        LONG_EN   = (LONG_PRESS_MS >= 1) && (LONG_PRESS_MS <= 65535);

  state_e      state_q, state_d;
  logic        sync1_q, sync1_d, sync2_q, sync2_d;
  logic [15:0] ms_q, ms_d, hold_q, hold_d, hold_ms_q, hold_ms_d;
  logic        level_q, level_d, press_q, press_d, rel_q, rel_d;
  logic        long_q, long_d, flag_q, flag_d;
  logic        btn_s, tick_s, clr_s;

  assign btn_s = sync2_q;
  assign clr_s = (state_d != state_q);

  ms_tick_gen #(.CLK_FREQ(CLK_FREQ)) u_tick (
    .CLK  (CLK),
    .RST  (RST),
    .CLR  (clr_s),
    .TICK (tick_s)
  );

  always_comb begin
    sync1_d   = BTN_IN;
    sync2_d   = sync1_q;
    state_d   = state_q;
    ms_d      = ms_q;
    hold_d    = hold_q;
    hold_ms_d = hold_ms_q;
    level_d   = level_q;
    flag_d    = flag_q;
    press_d   = 1'b0;
    rel_d     = 1'b0;
    long_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (btn_s) begin
          state_d = ST_PRESS_WAIT;
          ms_d    = 16'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PRESS_WAIT: begin
        if (!btn_s) begin
          state_d = ST_IDLE;
        end else if (tick_s) begin
          if (ms_q == DEB_LAST) begin
            state_d = ST_PRESSED;
            press_d = 1'b1;
            level_d = 1'b1;
            hold_d  = 16'd0;
          end else begin
            ms_d = ms_q + 16'd1;
          end
        end else begin
          ms_d = ms_q;
        end
      end
      ST_PRESSED: begin
        // A falling btn_s wins over a coincident tick, so that cycle is not counted.
        if (!btn_s) begin
          state_d = ST_RELEASE_WAIT;
          ms_d    = 16'd0;
        end else if (tick_s) begin
          if (hold_q != SAT_MAX) begin
            hold_d = hold_q + 16'd1;
          end else begin
            hold_d = hold_q;
          end
          if (LONG_EN && !flag_q && (hold_q == LONG_LAST)) begin
            long_d = 1'b1;
            flag_d = 1'b1;
          end else begin
            long_d = 1'b0;
          end
        end else begin
          hold_d = hold_q;
        end
      end
      ST_RELEASE_WAIT: begin
        if (btn_s) begin
          state_d = ST_PRESSED;
        end else if (tick_s) begin
          if (ms_q == DEB_LAST) begin
            state_d   = ST_IDLE;
            rel_d     = 1'b1;
            level_d   = 1'b0;
            flag_d    = 1'b0;
            hold_ms_d = hold_q;
          end else begin
            ms_d = ms_q + 16'd1;
          end
        end else begin
          ms_d = ms_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      ms_q      <= 16'd0;
      hold_q    <= 16'd0;
      hold_ms_q <= 16'd0;
      level_q   <= 1'b0;
      flag_q    <= 1'b0;
      press_q   <= 1'b0;
      rel_q     <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      ms_q      <= ms_d;
      hold_q    <= hold_d;
      hold_ms_q <= hold_ms_d;
      level_q   <= level_d;
      flag_q    <= flag_d;
      press_q   <= press_d;
      rel_q     <= rel_d;
      long_q    <= long_d;
    end
  end

  assign BTN_LEVEL     = level_q;
  assign PRESS_PULSE   = press_q;
  assign RELEASE_PULSE = rel_q;
  assign LONG_PULSE    = long_q;
  assign LONG_FLAG     = flag_q;
  assign HOLD_MS       = hold_ms_q;

endmodule

// File: tb/tb_btn_debounce_press.sv
// Self-checking bench for btn_debounce_press: per-cycle comparison against a
// run-length reference model plus directed latency and hold-time checks.
module tb_btn_debounce_press;

  localparam int CLK_FREQ = 10_000;
  localparam int DEB      = 2;
  localparam int LONG     = 5;
  localparam int TPM      = CLK_FREQ / 1000;
  localparam int DEBC     = DEB * TPM;

  logic        CLK = 1'b0;
  logic        RST;
  logic        BTN_IN;
  logic        BTN_LEVEL, PRESS_PULSE, RELEASE_PULSE, LONG_PULSE, LONG_FLAG;
  logic [15:0] HOLD_MS;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  // Reference model: debounced level flips after DEBC+1 consecutive differing
  // samples of the synchronized input; whole ms of each unbroken pressed run count.
  logic        m_s1, m_s2, m_level, m_press, m_rel, m_long, m_lf;
  logic [15:0] m_hold, m_hold_ms;
  int          m_mis, m_run;

  btn_debounce_press #(
    .CLK_FREQ     (CLK_FREQ),
    .DEBOUNCE_MS  (DEB),
    .LONG_PRESS_MS(LONG)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .BTN_IN       (BTN_IN),
    .BTN_LEVEL    (BTN_LEVEL),
    .PRESS_PULSE  (PRESS_PULSE),
    .RELEASE_PULSE(RELEASE_PULSE),
    .LONG_PULSE   (LONG_PULSE),
    .LONG_FLAG    (LONG_FLAG),
    .HOLD_MS      (HOLD_MS)
  );

  always #5 CLK = ~CLK;

  function automatic logic [20:0] dut_vec();
    return {BTN_LEVEL, PRESS_PULSE, RELEASE_PULSE, LONG_PULSE, LONG_FLAG, HOLD_MS};
  endfunction

  function automatic logic [20:0] model_vec();
    return {m_level, m_press, m_rel, m_long, m_lf, m_hold_ms};
  endfunction

  task automatic model_reset();
    m_s1 = 1'b0; m_s2 = 1'b0; m_level = 1'b0; m_press = 1'b0; m_rel = 1'b0;
    m_long = 1'b0; m_lf = 1'b0; m_hold = 16'd0; m_hold_ms = 16'd0;
    m_mis = 0; m_run = 0;
  endtask

  task automatic model_edge();
    logic fin;
    fin = m_s2;
    m_s2 = m_s1;
    m_s1 = BTN_IN;
    m_press = 1'b0; m_rel = 1'b0; m_long = 1'b0;
    if (fin != m_level) begin
      m_mis++;
      if (m_mis == DEBC + 1) begin
        m_level = fin; m_mis = 0; m_run = 0;
        if (fin) begin
          m_press = 1'b1; m_hold = 16'd0;
        end else begin
          m_rel = 1'b1; m_lf = 1'b0; m_hold_ms = m_hold;
        end
      end
    end else if (m_mis > 0) begin
      m_mis = 0; m_run = 0;
    end else if (m_level) begin
      m_run++;
      if (m_run % TPM == 0) begin
        if (m_hold != 16'hFFFF) m_hold = m_hold + 16'd1;
        if (m_hold == 16'(LONG) && !m_lf) begin
          m_long = 1'b1; m_lf = 1'b1;
        end
      end
    end
  endtask

  task automatic step(input logic b);
    BTN_IN = b;
    @(posedge CLK);
    model_edge();
    edge_n++;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b1; BTN_IN = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (dut_vec() !== 21'd0) begin
      errors++; $display("FAIL reset_hold: outputs=%h expected=%h", dut_vec(), 21'd0);
    end
    RST = 1'b0;
    model_reset();
    for (int i = 0; i < 50; i++) begin
      step(1'b0);
      checks++;
      if (dut_vec() !== 21'd0) begin
        errors++; $display("FAIL reset_idle cyc%0d: outputs=%h expected=%h", i, dut_vec(), 21'd0);
      end
    end
  endtask

  task automatic test_bounce_press();
    int presses = 0;
    for (int r = 0; r < 3; r++) begin
      int n1 = $urandom_range(DEBC - 8, DEBC - 5);
      int n0 = $urandom_range(3, 10);
      for (int i = 0; i < n1 + n0; i++) begin
        step(i < n1);
        if (PRESS_PULSE) presses++;
        checks++;
        if (dut_vec() !== model_vec()) begin
          errors++; $display("FAIL bounce_press r%0d c%0d: dut=%h model=%h", r, i, dut_vec(), model_vec());
        end
      end
    end
    checks++;
    if (presses !== 0 || BTN_LEVEL !== 1'b0) begin
      errors++; $display("FAIL bounce_press_none: presses=%0d level=%b expected 0/0", presses, BTN_LEVEL);
    end
  endtask

  task automatic test_press();
    int start = edge_n;
    int press_at = -1;
    int others = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b1);
      if (PRESS_PULSE) press_at = edge_n - start;
      if (RELEASE_PULSE || LONG_PULSE) others++;
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL press c%0d: dut=%h model=%h", i, dut_vec(), model_vec());
      end
    end
    checks++;
    if (press_at !== DEBC + 3 || others !== 0 || BTN_LEVEL !== 1'b1) begin
      errors++; $display("FAIL press_latency: edge=%0d others=%0d level=%b expected %0d/0/1",
                         press_at, others, BTN_LEVEL, DEBC + 3);
    end
    for (int i = 0; i < 30; i++) begin
      step(1'b0);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL press_release c%0d: dut=%h model=%h", i, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_long_release();
    int press_at = -1;
    int long_at = -1;
    int rel_at = -1;
    int start;
    for (int i = 0; i < 30 && press_at < 0; i++) begin
      step(1'b1);
      if (PRESS_PULSE) press_at = edge_n;
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL long_press c%0d: dut=%h model=%h", i, dut_vec(), model_vec());
      end
    end
    for (int i = 0; i < 80; i++) begin
      step(1'b1);
      if (LONG_PULSE) long_at = edge_n;
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL long_hold c%0d: dut=%h model=%h", i, dut_vec(), model_vec());
      end
    end
    checks++;
    if (press_at < 0 || long_at - press_at !== LONG * TPM || LONG_FLAG !== 1'b1) begin
      errors++; $display("FAIL long_timing: press=%0d long=%0d flag=%b expected delta %0d flag 1",
                         press_at, long_at, LONG_FLAG, LONG * TPM);
    end
    start = edge_n;
    for (int i = 0; i < 30; i++) begin
      step(1'b0);
      if (RELEASE_PULSE) rel_at = edge_n - start;
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL long_release c%0d: dut=%h model=%h", i, dut_vec(), model_vec());
      end
    end
    checks++;
    if (rel_at !== DEBC + 3 || HOLD_MS !== 16'd8 || LONG_FLAG !== 1'b0 || BTN_LEVEL !== 1'b0) begin
      errors++; $display("FAIL release_result: edge=%0d hold=%0d flag=%b level=%b expected %0d/8/0/0",
                         rel_at, HOLD_MS, LONG_FLAG, BTN_LEVEL, DEBC + 3);
    end
  endtask

  task automatic test_bounce_pressed();
    int gap = $urandom_range(5, 15);
    int evts = 0;
    for (int i = 0; i < 30; i++) begin
      step(1'b1);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL bp_press c%0d: dut=%h model=%h", i, dut_vec(), model_vec());
      end
    end
    for (int i = 0; i < gap + 40; i++) begin
      step(i >= gap);
      if (PRESS_PULSE || RELEASE_PULSE) evts++;
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL bp_bounce c%0d: dut=%h model=%h", i, dut_vec(), model_vec());
      end
    end
    checks++;
    if (evts !== 0 || BTN_LEVEL !== 1'b1) begin
      errors++; $display("FAIL bp_no_event: events=%0d level=%b expected 0/1", evts, BTN_LEVEL);
    end
    for (int i = 0; i < 30; i++) begin
      step(1'b0);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL bp_release c%0d: dut=%h model=%h", i, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int s = 0; s < 25; s++) begin
      logic lvl = 1'($urandom_range(0, 1));
      int   len = $urandom_range(1, 60);
      for (int i = 0; i < len; i++) begin
        step(lvl);
        checks++;
        if (dut_vec() !== model_vec()) begin
          errors++; $display("FAIL random s%0d c%0d: dut=%h model=%h", s, i, dut_vec(), model_vec());
        end
      end
    end
  endtask

  task automatic test_async_reset();
    int press_at = -1;
    int start;
    for (int i = 0; i < 90; i++) begin
      step(1'b1);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL ar_hold c%0d: dut=%h model=%h", i, dut_vec(), model_vec());
      end
    end
    checks++;
    if (LONG_FLAG !== 1'b1) begin
      errors++; $display("FAIL ar_flag_before: flag=%b expected 1", LONG_FLAG);
    end
    #2 RST = 1'b1;
    #1;
    checks++;
    if (dut_vec() !== 21'd0) begin
      errors++; $display("FAIL ar_immediate: outputs=%h expected=%h", dut_vec(), 21'd0);
    end
    model_reset();
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    start = edge_n;
    for (int i = 0; i < 30; i++) begin
      step(1'b1);
      if (PRESS_PULSE) press_at = edge_n - start;
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL ar_repress c%0d: dut=%h model=%h", i, dut_vec(), model_vec());
      end
    end
    checks++;
    if (press_at !== DEBC + 3) begin
      errors++; $display("FAIL ar_press_latency: edge=%0d expected %0d", press_at, DEBC + 3);
    end
  endtask

  initial begin
    RST = 1'b1;
    BTN_IN = 1'b0;
    model_reset();
    test_reset();
    test_bounce_press();
    test_press();
    test_long_release();
    test_bounce_pressed();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
